// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_pkg
// Purpose  : Shared register-file constants, write-sequencer state encoding
//            and a constant clog2 helper for width calculations.
// Revision : 1.0 - initial release
// ============================================================================
package regfile_pkg;

  localparam int RF_WIDTH  = 16;
  localparam int RF_DEPTH  = 8;
  localparam int RF_ADDR_W = 3;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_t;

  // Ceiling log2, usable in parameter and port-width expressions
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational rotating-priority pick. Returns the first eligible
//            request (req & ~mask) found searching upward from i_ptr, wrapping
//            modulo N.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import regfile_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = clog2(N)
) (
  input  logic [N-1:0]   i_req,
  input  logic [N-1:0]   i_mask,
  input  logic [IDW-1:0] i_ptr,
  output logic [IDW-1:0] o_idx,
  output logic           o_valid
);

  localparam logic [IDW:0] C_N = (IDW+1)'(N);

  logic [N-1:0] w_elig;
  logic [IDW:0] w_sum;

  assign w_elig = i_req & ~i_mask;

  // Walk offsets from farthest to nearest so the nearest hit wins
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    w_sum   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_sum = {1'b0, i_ptr} + (IDW+1)'(k);
      if (w_sum >= C_N) w_sum = w_sum - C_N;
      if (w_elig[w_sum[IDW-1:0]]) begin
        o_valid = 1'b1;
        o_idx   = w_sum[IDW-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wr_arbiter
// Purpose  : Round-robin write arbiter/sequencer for the 8x16 register file.
//            Grants one requester per cycle, latches its address/data and
//            issues a registered one-cycle write strobe plus ack pulse.
//            Optional macro REGFILE_WR_LOCK_EN adds lock_mask/err: writes to
//            locked registers are acked with err and not issued.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wr_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = RF_WIDTH,
  parameter int DEPTH   = RF_DEPTH,
  parameter int ADDR_W  = RF_ADDR_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*WIDTH-1:0]    req_data,
`ifdef REGFILE_WR_LOCK_EN
  input  logic [DEPTH-1:0]            lock_mask,
  output logic [NUM_REQ-1:0]          err,
`endif
  output logic [NUM_REQ-1:0]          ack,
  output logic                        rf_wr_en,
  output logic [ADDR_W-1:0]           rf_addr,
  output logic [WIDTH-1:0]            rf_wr_data,
  output logic                        busy,
  output logic [clog2(NUM_REQ)-1:0]   gnt_id
);

  localparam int ID_W = clog2(NUM_REQ);

  // Elaboration-time guard against inconsistent sizing
  if ((ADDR_W != clog2(DEPTH)) || (NUM_REQ < 2) || (NUM_REQ > 8)) begin : g_cfg_check
    $error("regfile_wr_arbiter: invalid NUM_REQ/DEPTH/ADDR_W combination");
  end

  state_t              r_state;
  logic [ID_W-1:0]     r_ptr;
  logic [ID_W-1:0]     r_gnt_id;
  logic [NUM_REQ-1:0]  r_ack;
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_addr;
  logic [WIDTH-1:0]    r_data;
  logic                r_busy;
`ifdef REGFILE_WR_LOCK_EN
  logic [NUM_REQ-1:0]  r_err;
`endif

  logic [NUM_REQ-1:0]  w_mask;
  logic [ID_W-1:0]     w_next_ptr;
  logic [ID_W-1:0]     w_sptr;
  logic [ID_W-1:0]     w_idx;
  logic                w_valid;
  logic [ADDR_W-1:0]   w_addr;
  logic [WIDTH-1:0]    w_data;

  // While writing, the grantee's req is still high: hide it and search from
  // the slot after it so back-to-back grants rotate fairly.
  assign w_mask     = (r_state == ST_WRITE) ? (NUM_REQ'(1) << r_gnt_id) : '0;
  assign w_next_ptr = (r_gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : r_gnt_id + 1'b1;
  assign w_sptr     = (r_state == ST_WRITE) ? w_next_ptr : r_ptr;

  rr_arbiter #(
    .N   (NUM_REQ),
    .IDW (ID_W)
  ) u_rr_arbiter (
    .i_req   (req),
    .i_mask  (w_mask),
    .i_ptr   (w_sptr),
    .o_idx   (w_idx),
    .o_valid (w_valid)
  );

  // Select the winner's address and data slices
  always_comb begin
    w_addr = '0;
    w_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_idx == ID_W'(i)) begin
        w_addr = req_addr[i*ADDR_W +: ADDR_W];
        w_data = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // IDLE/WRITE sequencer: any grant (from either state) lands in WRITE next
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_ptr    <= '0;
      r_gnt_id <= '0;
      r_ack    <= '0;
      r_wr_en  <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
      r_busy   <= 1'b0;
`ifdef REGFILE_WR_LOCK_EN
      r_err    <= '0;
`endif
    end else begin
      if (r_state == ST_WRITE) r_ptr <= w_next_ptr;
      if (w_valid) begin
        r_state  <= ST_WRITE;
        r_gnt_id <= w_idx;
        r_ack    <= NUM_REQ'(1) << w_idx;
        r_addr   <= w_addr;
        r_data   <= w_data;
        r_busy   <= 1'b1;
`ifdef REGFILE_WR_LOCK_EN
        r_wr_en  <= ~lock_mask[w_addr];
        r_err    <= lock_mask[w_addr] ? (NUM_REQ'(1) << w_idx) : '0;
`else
        r_wr_en  <= 1'b1;
`endif
      end else begin
        r_state  <= ST_IDLE;
        r_ack    <= '0;
        r_wr_en  <= 1'b0;
        r_busy   <= 1'b0;
`ifdef REGFILE_WR_LOCK_EN
        r_err    <= '0;
`endif
      end
    end
  end

  assign ack        = r_ack;
  assign rf_wr_en   = r_wr_en;
  assign rf_addr    = r_addr;
  assign rf_wr_data = r_data;
  assign busy       = r_busy;
  assign gnt_id     = r_gnt_id;
`ifdef REGFILE_WR_LOCK_EN
  assign err        = r_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wr_arbiter
// Purpose  : Directed self-checking bench for regfile_wr_arbiter (NUM_REQ=4).
//            Includes the lock test when REGFILE_WR_LOCK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = '0;
  logic [11:0] req_addr = '0;
  logic [63:0] req_data = '0;
  logic [3:0]  ack;
  logic        rf_wr_en;
  logic [2:0]  rf_addr;
  logic [15:0] rf_wr_data;
  logic        busy;
  logic [1:0]  gnt_id;
`ifdef REGFILE_WR_LOCK_EN
  logic [7:0]  lock_mask = '0;
  logic [3:0]  err;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] mem [8];

  regfile_wr_arbiter #(
    .NUM_REQ (4),
    .WIDTH   (16),
    .DEPTH   (8),
    .ADDR_W  (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_addr   (req_addr),
    .req_data   (req_data),
`ifdef REGFILE_WR_LOCK_EN
    .lock_mask  (lock_mask),
    .err        (err),
`endif
    .ack        (ack),
    .rf_wr_en   (rf_wr_en),
    .rf_addr    (rf_addr),
    .rf_wr_data (rf_wr_data),
    .busy       (busy),
    .gnt_id     (gnt_id)
  );

  always #5 clk = ~clk;

  // Register file model written by the strobe
  always @(posedge clk) begin
    if (rf_wr_en) mem[rf_addr] <= rf_wr_data;
  end

  task automatic set_slot(input int i, input logic [2:0] a, input logic [15:0] d);
    req_addr[i*3 +: 3]   = a;
    req_data[i*16 +: 16] = d;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req = 4'b1111;
    repeat (3) @(negedge clk);
    n_vec++; if (ack !== 4'b0000) begin n_err++; $display("FAIL reset_ack: got %b expected 0000", ack); end
    n_vec++; if (rf_wr_en !== 1'b0) begin n_err++; $display("FAIL reset_wr_en: got %b expected 0", rf_wr_en); end
    n_vec++; if (rf_addr !== 3'd0) begin n_err++; $display("FAIL reset_addr: got %0d expected 0", rf_addr); end
    n_vec++; if (rf_wr_data !== 16'h0000) begin n_err++; $display("FAIL reset_data: got %h expected 0000", rf_wr_data); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_vec++; if (gnt_id !== 2'd0) begin n_err++; $display("FAIL reset_gnt_id: got %0d expected 0", gnt_id); end
    rst = 1'b1;
    @(negedge clk);
    n_vec++; if (ack !== 4'b0001) begin n_err++; $display("FAIL reset_first_ack: got %b expected 0001", ack); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL reset_first_busy: got %b expected 1", busy); end
    req = 4'b0000;
    @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_idle_after: got %b expected 0", busy); end
  endtask

  task automatic test_single();
    set_slot(2, 3'd5, 16'hA5A5);
    req = 4'b0100;
    @(negedge clk);
    req = 4'b0000;
    set_slot(2, 3'd1, 16'hFFFF);
    n_vec++; if (ack !== 4'b0100) begin n_err++; $display("FAIL single_ack: got %b expected 0100", ack); end
    n_vec++; if (rf_wr_en !== 1'b1) begin n_err++; $display("FAIL single_wr_en: got %b expected 1", rf_wr_en); end
    n_vec++; if (rf_addr !== 3'd5) begin n_err++; $display("FAIL single_addr: got %0d expected 5", rf_addr); end
    n_vec++; if (rf_wr_data !== 16'hA5A5) begin n_err++; $display("FAIL single_data: got %h expected a5a5", rf_wr_data); end
    n_vec++; if (gnt_id !== 2'd2) begin n_err++; $display("FAIL single_gnt_id: got %0d expected 2", gnt_id); end
    @(negedge clk);
    n_vec++; if (mem[5] !== 16'hA5A5) begin n_err++; $display("FAIL single_readback: got %h expected a5a5", mem[5]); end
    n_vec++; if ({busy, rf_wr_en, ack} !== 6'b000000) begin n_err++; $display("FAIL single_end: got %b expected 000000", {busy, rf_wr_en, ack}); end
  endtask

  task automatic test_contention();
    logic [3:0] exp_ack [5];
    exp_ack[0] = 4'b0001; exp_ack[1] = 4'b0010; exp_ack[2] = 4'b0100;
    exp_ack[3] = 4'b1000; exp_ack[4] = 4'b0001;
    // Restart the rotation from requester 0
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) set_slot(i, 3'(i + 1), 16'h1000 + 16'(i));
    req = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_vec++; if (ack !== exp_ack[c]) begin n_err++; $display("FAIL contention_ack[%0d]: got %b expected %b", c, ack, exp_ack[c]); end
      n_vec++; if (rf_wr_en !== 1'b1) begin n_err++; $display("FAIL contention_wr_en[%0d]: got %b expected 1", c, rf_wr_en); end
    end
    req = 4'b0000;
    @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL contention_idle: got %b expected 0", busy); end
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (mem[i+1] !== 16'h1000 + 16'(i)) begin n_err++; $display("FAIL contention_mem[%0d]: got %h expected %h", i + 1, mem[i+1], 16'h1000 + 16'(i)); end
    end
  endtask

  task automatic test_masking();
    int acks;
    acks = 0;
    set_slot(1, 3'd2, 16'h2222);
    req = 4'b0010;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (ack != 4'b0000) acks++;
      if (c == 1) req = 4'b0000;
    end
    n_vec++; if (acks !== 1) begin n_err++; $display("FAIL masking_ack_count: got %0d expected 1", acks); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL masking_busy: got %b expected 0", busy); end
    n_vec++; if (mem[2] !== 16'h2222) begin n_err++; $display("FAIL masking_mem: got %h expected 2222", mem[2]); end
  endtask

  task automatic test_wrap();
    // Pointer sits at 2 after the masking test: requester 3 wins, then 0
    set_slot(3, 3'd7, 16'h7777);
    set_slot(0, 3'd6, 16'h6666);
    req = 4'b1001;
    @(negedge clk);
    n_vec++; if (ack !== 4'b1000) begin n_err++; $display("FAIL wrap_ack0: got %b expected 1000", ack); end
    req = 4'b0001;
    @(negedge clk);
    n_vec++; if (ack !== 4'b0001) begin n_err++; $display("FAIL wrap_ack1: got %b expected 0001", ack); end
    n_vec++; if (rf_addr !== 3'd6) begin n_err++; $display("FAIL wrap_addr: got %0d expected 6", rf_addr); end
    req = 4'b0000;
    @(negedge clk);
    n_vec++; if (mem[7] !== 16'h7777) begin n_err++; $display("FAIL wrap_mem7: got %h expected 7777", mem[7]); end
  endtask

  task automatic test_reset_mid();
    mem[6] = 16'h0000;
    set_slot(2, 3'd6, 16'hDEAD);
    req = 4'b0100;
    @(posedge clk);
    #2;
    n_vec++; if (rf_wr_en !== 1'b1) begin n_err++; $display("FAIL midrst_pre_wr_en: got %b expected 1", rf_wr_en); end
    rst = 1'b0;
    #1;
    n_vec++; if (rf_wr_en !== 1'b0) begin n_err++; $display("FAIL midrst_wr_en: got %b expected 0", rf_wr_en); end
    n_vec++; if (ack !== 4'b0000) begin n_err++; $display("FAIL midrst_ack: got %b expected 0000", ack); end
    @(negedge clk);
    set_slot(0, 3'd0, 16'h0000);
    req = 4'b1111;
    rst = 1'b1;
    @(negedge clk);
    n_vec++; if (ack !== 4'b0001) begin n_err++; $display("FAIL midrst_ptr0_ack: got %b expected 0001", ack); end
    req = 4'b0000;
    @(negedge clk);
    n_vec++; if (mem[6] !== 16'h0000) begin n_err++; $display("FAIL midrst_dropped: got %h expected 0000", mem[6]); end
  endtask

`ifdef REGFILE_WR_LOCK_EN
  task automatic test_lock();
    lock_mask = 8'h08;
    set_slot(0, 3'd3, 16'hBEEF);
    req = 4'b0001;
    @(negedge clk);
    req = 4'b0000;
    n_vec++; if (ack !== 4'b0001) begin n_err++; $display("FAIL lock_ack: got %b expected 0001", ack); end
    n_vec++; if (err !== 4'b0001) begin n_err++; $display("FAIL lock_err: got %b expected 0001", err); end
    n_vec++; if (rf_wr_en !== 1'b0) begin n_err++; $display("FAIL lock_wr_en: got %b expected 0", rf_wr_en); end
    @(negedge clk);
    n_vec++; if (mem[3] !== 16'h1002) begin n_err++; $display("FAIL lock_mem3: got %h expected 1002", mem[3]); end
    set_slot(0, 3'd4, 16'hCAFE);
    req = 4'b0001;
    @(negedge clk);
    req = 4'b0000;
    n_vec++; if (err !== 4'b0000) begin n_err++; $display("FAIL unlock_err: got %b expected 0000", err); end
    n_vec++; if (rf_wr_en !== 1'b1) begin n_err++; $display("FAIL unlock_wr_en: got %b expected 1", rf_wr_en); end
    @(negedge clk);
    n_vec++; if (mem[4] !== 16'hCAFE) begin n_err++; $display("FAIL unlock_mem4: got %h expected cafe", mem[4]); end
    lock_mask = 8'h00;
  endtask
`endif

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 16'h0000;
    test_reset();
    test_single();
    test_contention();
    test_masking();
    test_wrap();
    test_reset_mid();
`ifdef REGFILE_WR_LOCK_EN
    test_lock();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
